im_responder: RTL and testbench
===============================

// Module: im_responder
// PURPOSE
//  Instruction-memory responder: the memory end of the fetch interface. Accepts
//  fetch requests (byte address), returns the 32-bit word after a fixed wait-state
//  latency via a valid/ready handshake. Provides a word-write load port so a bench
//  or boot loader can fill program memory. Sits between the fetch unit and storage.
// PARAMETERS
//  ADDR_W   10       byte-address bits of storage (2^ADDR_W bytes, 2^(ADDR_W-2) words)
//  BASE     32'h3000 byte address of word 0 (PC reset value)
//  LATENCY  2        cycles from request accept to rsp_valid; legal range 1..15
// PORTS
//  clk        in   1   clock, all state updates on posedge
//  reset      in   1   synchronous, active-high
//  req_valid  in   1   fetch request present
//  req_ready  out  1   responder can accept a request this cycle
//  req_addr   in   32  fetch byte address
//  rsp_valid  out  1   response word valid
//  rsp_ready  in   1   consumer takes response this cycle
//  rsp_inst   out  32  fetched instruction word
//  rsp_err    out  1   misaligned or out-of-range request; rsp_inst = 0 (nop)
//  load_en    in   1   write one word into storage
//  load_addr  in   32  load byte address (BASE-relative, same mapping as fetch)
//  load_data  in   32  load word
// BEHAVIOUR
//  - Reset (sync, active-high): state=IDLE, rsp_valid=0, rsp_inst=0, rsp_err=0, counter=0,
//    pending request discarded; storage contents NOT cleared. Reset mid-WAIT or mid-RESP
//    aborts the transaction, with no response issued.
//  - Address map: off = addr - BASE (32-bit wrap); index = off[ADDR_W-1:2].
//    err = (addr[1:0] != 0) | (off >= 2^ADDR_W).
//  - req_ready = (state == IDLE) & ~load_en (combinational).
//  - FSM: IDLE -> WAIT on req_valid & req_ready: latch index/err, cnt <= LATENCY-1.
//    WAIT: if cnt == 0 -> RESP; rsp_inst <= err ? 0 : mem[index]; rsp_err <= err;
//    rsp_valid <= 1. Else cnt <= cnt-1.
//    RESP: hold rsp_valid/rsp_inst/rsp_err stable until rsp_ready; on rsp_valid &
//    rsp_ready -> IDLE, rsp_valid <= 0 (rsp_inst/rsp_err keep last value).
//  - Latency: accept edge to rsp_valid high = exactly LATENCY cycles. Min request
//    period = LATENCY+2 cycles (the response is taken in the first RESP cycle, with
//    no back-to-back accept in the same cycle).
//  - Load port: on load_en, if load_addr is aligned and in range, mem[index] <= load_data;
//    otherwise the write is dropped silently. Legal in any state.
//  - Collision: a load to the index of a pending fetch before the WAIT->RESP edge is
//    visible in the response; a load on the WAIT->RESP edge itself returns OLD data
//    (read-before-write). A load during RESP does not alter the held rsp_inst.
//  - Simultaneous load_en and req_valid in IDLE: the load is performed, the request is
//    not accepted (req_ready=0) and must be held by the requester.
//  - Storage: single array, one write and one read port, inferred as distributed/regs.
// STRUCTURE
//  - Shared defines: the IM_BASE constant (32'h3000), the NOP word (32'h0), and the
//    FSM state encodings IDLE=2'd0, WAIT=2'd1, RESP=2'd2.
//  - One natural sub-module: im_store (word array: one write port and one async read
//    port, parameter WORDS). FSM, counter and address check stay in im_responder.
// TESTING
//  - Load 0x3000->0x24010001, 0x3004->0x24020002; fetch 0x3000, rsp_ready=1 ->
//    rsp_valid exactly 2 cycles after accept, rsp_inst=0x24010001, rsp_err=0.
//  - Fetch 0x3004 with rsp_ready=0 for 5 cycles -> rsp_valid/rsp_inst=0x24020002 held
//    stable, req_ready=0 throughout; 1 cycle after rsp_ready=1 -> IDLE, req_ready=1.
//  - Fetch 0x3002 -> rsp_err=1, rsp_inst=0; fetch 0x3400 -> rsp_err=1; fetch 0x2FFC
//    -> rsp_err=1; load to 0x3400 leaves word 0 unchanged.
//  - In IDLE assert load_en and req_valid together -> req_ready=0, word written;
//    next cycle the request is accepted. Load the pending index 1 cycle after accept
//    -> response carries the new data.
//  - Assert reset during WAIT -> rsp_valid stays 0, state IDLE; re-fetch 0x3000 ->
//    returns the pre-reset loaded word (storage preserved).
//  - LATENCY=1 and LATENCY=15 builds: accept-to-rsp_valid equals LATENCY.

Source files
------------

// File: rtl/im_responder_pkg.sv
// Shared constants and FSM encoding for the instruction-memory responder.
package im_responder_pkg;

    localparam logic [31:0] IM_BASE = 32'h3000;
    localparam logic [31:0] NOP     = 32'h0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/im_store.sv
// Word storage for program memory: one synchronous write port, one async read port.
module im_store
    import im_responder_pkg::*;
#(
    parameter  int WORDS = 256,
    localparam int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    // No reset: program contents must survive a core reset.
    logic [31:0] mem_q [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/im_responder.sv
// Memory end of the fetch interface: fixed wait-state fetch responder with a word-load port.
module im_responder
    import im_responder_pkg::*;
#(
    parameter int          ADDR_W  = 10,
    parameter logic [31:0] BASE    = IM_BASE,
    parameter int          LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_inst,
    output logic        rsp_err,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data
);

    localparam int          IDX_W    = ADDR_W - 2;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               perr_q, perr_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_inst_q, rsp_inst_d;
    logic               rsp_err_q, rsp_err_d;

    // BASE is word-aligned, so the low offset bits equal the low address bits.
    logic [31:0]        req_off, load_off;
    logic               req_bad, load_bad;
    logic [IDX_W-1:0]   req_idx, load_idx;
    logic [31:0]        mem_rdata;

    assign req_off  = req_addr - BASE;
    assign load_off = load_addr - BASE;
    assign req_bad  = (|req_off[1:0]) | (|req_off[31:ADDR_W]);
    assign load_bad = (|load_off[1:0]) | (|load_off[31:ADDR_W]);
    assign req_idx  = req_off[ADDR_W-1:2];
    assign load_idx = load_off[ADDR_W-1:2];

    assign req_ready = (state_q == IDLE) & ~load_en;

    im_store #(
        .WORDS (1 << IDX_W)
    ) u_store (
        .clk   (clk),
        .we    (load_en & ~load_bad),
        .waddr (load_idx),
        .wdata (load_data),
        .raddr (idx_q),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            idx_q       <= '0;
            perr_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_inst_q  <= NOP;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            perr_q      <= perr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_inst_q  <= rsp_inst_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        perr_d      = perr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_inst_d  = rsp_inst_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    idx_d   = req_idx;
                    perr_d  = req_bad;
                    cnt_d   = CNT_INIT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    // Async read sampled here: a load on this same edge is not yet visible.
                    rsp_inst_d  = perr_q ? NOP : mem_rdata;
                    rsp_err_d   = perr_q;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_inst  = rsp_inst_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_im_responder.sv
// Scoreboard bench for im_responder: latency, stalls, address errors, load collisions, reset.
module tb_im_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, load_en;
    logic [31:0] req_addr, rsp_inst, load_addr, load_data;

    logic        s_req_valid, s_load_en, s_rsp_ready;
    logic [31:0] s_req_addr, s_load_addr, s_load_data;
    logic        l1_req_ready, l1_rsp_valid, l1_rsp_err;
    logic        l15_req_ready, l15_rsp_valid, l15_rsp_err;
    logic [31:0] l1_rsp_inst, l15_rsp_inst;

    always #5 clk = ~clk;

    im_responder #(.ADDR_W(10), .BASE(32'h3000), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_inst(rsp_inst), .rsp_err(rsp_err), .load_en(load_en),
        .load_addr(load_addr), .load_data(load_data)
    );

    im_responder #(.ADDR_W(10), .BASE(32'h3000), .LATENCY(1)) dut_l1 (
        .clk(clk), .reset(reset), .req_valid(s_req_valid), .req_ready(l1_req_ready),
        .req_addr(s_req_addr), .rsp_valid(l1_rsp_valid), .rsp_ready(s_rsp_ready),
        .rsp_inst(l1_rsp_inst), .rsp_err(l1_rsp_err), .load_en(s_load_en),
        .load_addr(s_load_addr), .load_data(s_load_data)
    );

    im_responder #(.ADDR_W(10), .BASE(32'h3000), .LATENCY(15)) dut_l15 (
        .clk(clk), .reset(reset), .req_valid(s_req_valid), .req_ready(l15_req_ready),
        .req_addr(s_req_addr), .rsp_valid(l15_rsp_valid), .rsp_ready(s_rsp_ready),
        .rsp_inst(l15_rsp_inst), .rsp_err(l15_rsp_err), .load_en(s_load_en),
        .load_addr(s_load_addr), .load_data(s_load_data)
    );

    typedef struct packed {
        logic [31:0] inst;
        logic        err;
    } rsp_t;

    rsp_t        sb_q[$];
    logic [31:0] model_mem [256];
    int          checks = 0;
    int          errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit addr_bad(input logic [31:0] a);
        logic [31:0] off;
        off = a - 32'h3000;
        return (a[1:0] != 2'b00) || (off >= 32'd1024);
    endfunction

    function automatic int widx(input logic [31:0] a);
        logic [31:0] off;
        off = (a - 32'h3000) >> 2;
        return int'(off[7:0]);
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d);
        if (!addr_bad(a)) model_mem[widx(a)] = d;
    endtask

    task automatic do_load(input logic [31:0] a, input logic [31:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        step();
        load_en = 1'b0;
        #1;
        model_write(a, d);
        $display("load  addr=%h data=%h", a, d);
    endtask

    // ld_at: cycle after accept at which to load the pending word (-1 = none).
    task automatic fetch(input string tag, input logic [31:0] a, input int stall,
                         input bit ld_first, input int ld_at, input bit resp_ld,
                         input logic [31:0] ld_data);
        rsp_t        e;
        int          n;
        int          lat;
        logic [31:0] held;
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = a;
        if (ld_first) begin
            load_en = 1'b1; load_addr = a; load_data = ld_data;
            #1;
            check_val({tag, " ready_during_load"}, 32'(req_ready), 32'd0);
            step();
            load_en = 1'b0;
            #1;
            model_write(a, ld_data);
        end
        n = 0;
        while (!req_ready && n < 20) begin
            step();
            n++;
        end
        check_val({tag, " accept"}, 32'(req_ready), 32'd1);
        if (!req_ready) begin
            req_valid = 1'b0;
            return;
        end
        if (addr_bad(a))                     e = '{inst: 32'h0, err: 1'b1};
        else if (ld_at >= 0 && ld_at < LAT-1) e = '{inst: ld_data, err: 1'b0};
        else                                  e = '{inst: model_mem[widx(a)], err: 1'b0};
        sb_q.push_back(e);
        step();
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            if (lat == ld_at) begin
                load_en = 1'b1; load_addr = a; load_data = ld_data;
            end
            step();
            if (lat == ld_at) begin
                load_en = 1'b0;
                model_write(a, ld_data);
            end
            lat++;
        end
        check_val({tag, " latency"}, 32'(lat), 32'(LAT));
        held = rsp_inst;
        for (int i = 0; i < stall; i++) begin
            if (resp_ld && i == 0) begin
                load_en = 1'b1; load_addr = a; load_data = ld_data;
            end
            step();
            if (resp_ld && i == 0) begin
                load_en = 1'b0;
                #1;
                model_write(a, ld_data);
            end
            check_val({tag, " stall_valid"}, 32'(rsp_valid), 32'd1);
            check_val({tag, " stall_inst"}, rsp_inst, held);
            check_val({tag, " stall_ready"}, 32'(req_ready), 32'd0);
        end
        check_val({tag, " sb_nonempty"}, 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val({tag, " valid"}, 32'(rsp_valid), 32'd1);
            check_val({tag, " inst"}, rsp_inst, e.inst);
            check_val({tag, " err"}, 32'(rsp_err), 32'(e.err));
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check_val({tag, " done_valid"}, 32'(rsp_valid), 32'd0);
        check_val({tag, " done_ready"}, 32'(req_ready), 32'd1);
        check_val({tag, " keep_inst"}, rsp_inst, e.inst);
        $display("fetch %s addr=%h inst=%h err=%0d lat=%0d", tag, a, rsp_inst, rsp_err, lat);
    endtask

    initial begin
        int l1;
        int l15;
        reset = 1'b1;
        req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        s_req_valid = 1'b0; s_req_addr = '0; s_rsp_ready = 1'b1;
        s_load_en = 1'b0; s_load_addr = '0; s_load_data = '0;
        for (int i = 0; i < 256; i++) model_mem[i] = '0;
        repeat (3) step();
        reset = 1'b0;
        #1;
        check_val("rst valid", 32'(rsp_valid), 32'd0);
        check_val("rst inst", rsp_inst, 32'd0);
        check_val("rst err", 32'(rsp_err), 32'd0);
        check_val("rst ready", 32'(req_ready), 32'd1);

        do_load(32'h3000, 32'h24010001);
        do_load(32'h3004, 32'h24020002);
        fetch("w0", 32'h3000, 0, 1'b0, -1, 1'b0, 32'h0);
        fetch("w1_stall", 32'h3004, 5, 1'b0, -1, 1'b0, 32'h0);
        fetch("misalign", 32'h3002, 0, 1'b0, -1, 1'b0, 32'h0);
        fetch("top_oor", 32'h3400, 0, 1'b0, -1, 1'b0, 32'h0);
        fetch("below", 32'h2FFC, 0, 1'b0, -1, 1'b0, 32'h0);
        do_load(32'h3400, 32'hBADBAD00);
        do_load(32'h3001, 32'hFFFFFFFF);
        fetch("w0_kept", 32'h3000, 0, 1'b0, -1, 1'b0, 32'h0);

        fetch("ld_first", 32'h3008, 0, 1'b1, -1, 1'b0, 32'hAAAA5555);
        do_load(32'h300C, 32'h00000001);
        fetch("coll_new", 32'h300C, 0, 1'b0, 0, 1'b0, 32'h12345678);
        do_load(32'h3010, 32'h00000011);
        fetch("coll_old", 32'h3010, 0, 1'b0, 1, 1'b0, 32'h00000022);
        fetch("coll_after", 32'h3010, 0, 1'b0, -1, 1'b0, 32'h0);
        fetch("resp_ld", 32'h3004, 3, 1'b0, -1, 1'b1, 32'hDEADBEEF);
        fetch("resp_ld_after", 32'h3004, 0, 1'b0, -1, 1'b0, 32'h0);

        // Abort a transaction mid-WAIT.
        req_valid = 1'b1; req_addr = 32'h3000;
        step();
        req_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check_val("abort ready", 32'(req_ready), 32'd1);
        check_val("abort inst", rsp_inst, 32'd0);
        for (int i = 0; i < 4; i++) begin
            check_val("abort valid", 32'(rsp_valid), 32'd0);
            step();
        end
        $display("reset during WAIT, no response");
        fetch("post_rst", 32'h3000, 0, 1'b0, -1, 1'b0, 32'h0);

        // LATENCY=1 and LATENCY=15 instances fetch the same word together.
        s_load_en = 1'b1; s_load_addr = 32'h3000; s_load_data = 32'hCAFEF00D;
        step();
        s_load_en = 1'b0;
        s_req_valid = 1'b1; s_req_addr = 32'h3000;
        #1;
        check_val("l1 ready", 32'(l1_req_ready), 32'd1);
        check_val("l15 ready", 32'(l15_req_ready), 32'd1);
        step();
        s_req_valid = 1'b0;
        l1 = 0; l15 = 0;
        for (int n = 1; n <= 40; n++) begin
            step();
            if (l1_rsp_valid && l1 == 0) l1 = n;
            if (l15_rsp_valid && l15 == 0) l15 = n;
        end
        check_val("l1 latency", 32'(l1), 32'd1);
        check_val("l15 latency", 32'(l15), 32'd15);
        check_val("l1 inst", l1_rsp_inst, 32'hCAFEF00D);
        check_val("l15 inst", l15_rsp_inst, 32'hCAFEF00D);
        $display("latency builds l1=%0d l15=%0d", l1, l15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
